// File: rtl/spi_burst_sequencer.sv
`timescale 1ns/1ps
// spi_burst_sequencer: runs multi-word bursts through the SPI byte-serial core.
// Pops the write FIFO, pulses go low, waits for pack-ready, pushes to read FIFO.
module spi_burst_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int GO_LOW  = 2,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_words,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  words_done,
    input  logic              wr_fifo_empty,
    input  logic [DATA_W-1:0] wr_fifo_q,
    output logic              wr_fifo_rdreq,
    input  logic              rd_fifo_full,
    output logic              rd_fifo_wrreq,
    output logic [DATA_W-1:0] rd_fifo_data,
    output logic              core_go_transfer,
    output logic [DATA_W-1:0] core_data_write,
    input  logic [DATA_W-1:0] core_data_read,
    input  logic              core_pack_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_GAP,
        S_DONE
    } state_t;

    // one shared counter serves go width, wait timeout and gap pacing
    localparam int CMAX = (TIMEOUT > GO_LOW)
                        ? ((TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC)
                        : ((GO_LOW > GAP_CYC) ? GO_LOW : GAP_CYC);
    localparam int TW = $clog2(CMAX + 1);

    localparam logic [TW-1:0] GO_LAST  = TW'(GO_LOW - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              pack_prev_q;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pack_rise;
    logic              abort_now;
    logic              gap_elapsed;
    logic [CNT_W-1:0]  wd_inc;

    assign pack_rise   = core_pack_ready && !pack_prev_q;
    assign abort_now   = abort_q || abort;
    assign gap_elapsed = (GAP_CYC == 0) || (cnt_q == GAP_LAST);
    assign wd_inc      = wd_q + CNT_W'(1);

    // word-boundary decision: abort, burst length, then FIFO level
    function automatic state_t gap_next(
        input logic [CNT_W-1:0] wd,
        input logic             ab,
        input logic [CNT_W-1:0] cfg,
        input logic             empty
    );
        state_t nxt;
        nxt = S_FETCH;
        if (ab) begin
            nxt = S_DONE;
        end else if (cfg != '0 && wd == cfg) begin
            nxt = S_DONE;
        end else if (empty) begin
            nxt = (cfg == '0) ? S_DONE : S_GAP;
        end
        return nxt;
    endfunction

    // state, counters and data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            pack_prev_q <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            pack_prev_q <= core_pack_ready;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // next-state and strobe decode
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        wd_d             = wd_q;
        err_d            = err_q;
        abort_d          = abort_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        done             = 1'b0;
        wr_fifo_rdreq    = 1'b0;
        rd_fifo_wrreq    = 1'b0;
        core_go_transfer = 1'b1;

        if (state_q != S_IDLE && abort) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    wd_d    = '0;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = wr_fifo_empty ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                wr_fifo_rdreq = 1'b1;
                wdata_d       = wr_fifo_q;
                cnt_d         = '0;
                state_d       = S_LAUNCH;
            end
            S_LAUNCH: begin
                core_go_transfer = 1'b0;
                if (cnt_q == GO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT: begin
                if (pack_rise) begin
                    rdata_d = core_data_read;
                    state_d = S_STORE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_STORE: begin
                if (!rd_fifo_full) begin
                    rd_fifo_wrreq = 1'b1;
                    wd_d          = wd_inc;
                    cnt_d         = '0;
                    if (GAP_CYC == 0) begin
                        state_d = gap_next(wd_inc, abort_now,
                                           cfg_words, wr_fifo_empty);
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_elapsed) begin
                    state_d = gap_next(wd_q, abort_now,
                                       cfg_words, wr_fifo_empty);
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = (state_q != S_IDLE);
    assign err_timeout     = err_q;
    assign words_done      = wd_q;
    assign rd_fifo_data    = rdata_q;
    assign core_data_write = wdata_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
`timescale 1ns/1ps
// tb_spi_burst_sequencer: FIFO, core and scoreboard models around the sequencer.
// Directed scenarios plus randomized bursts checked against a queue model.
module tb_spi_burst_sequencer;

    localparam int GO_LOW  = 2;
    localparam int TIMEOUT = 1024;
    localparam logic [31:0] KEY = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_words;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [7:0]  words_done;
    logic        wr_fifo_empty;
    logic [31:0] wr_fifo_q;
    logic        wr_fifo_rdreq;
    logic        rd_fifo_full;
    logic        rd_fifo_wrreq;
    logic [31:0] rd_fifo_data;
    logic        core_go_transfer;
    logic [31:0] core_data_write;
    logic [31:0] core_data_read = '0;
    logic        core_pack_ready = 1'b0;

    always #5 clk = ~clk;

    spi_burst_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .cfg_words        (cfg_words),
        .busy             (busy),
        .done             (done),
        .err_timeout      (err_timeout),
        .words_done       (words_done),
        .wr_fifo_empty    (wr_fifo_empty),
        .wr_fifo_q        (wr_fifo_q),
        .wr_fifo_rdreq    (wr_fifo_rdreq),
        .rd_fifo_full     (rd_fifo_full),
        .rd_fifo_wrreq    (rd_fifo_wrreq),
        .rd_fifo_data     (rd_fifo_data),
        .core_go_transfer (core_go_transfer),
        .core_data_write  (core_data_write),
        .core_data_read   (core_data_read),
        .core_pack_ready  (core_pack_ready)
    );

    // write FIFO: bench appends at the tail, DUT pops at the head
    logic [31:0] wmem [0:1023];
    int          wr_head = 0;
    int          wr_tail = 0;
    assign wr_fifo_empty = (wr_head == wr_tail);
    assign wr_fifo_q     = wmem[wr_head[9:0]];

    always @(posedge clk) begin
        if (wr_fifo_rdreq) wr_head <= wr_head + 1;
    end

    // read FIFO capture and protocol monitors
    logic [31:0] rmem [0:1023];
    int          rcnt = 0;
    int          both_cnt = 0;
    int          push_full = 0;
    int          fcnt = 0;
    assign rd_fifo_full = (fcnt != 0);

    always @(posedge clk) begin
        if (rd_fifo_wrreq) begin
            rmem[rcnt % 1024] <= rd_fifo_data;
            rcnt <= rcnt + 1;
            if (rd_fifo_full) push_full <= push_full + 1;
        end
        if (wr_fifo_rdreq && rd_fifo_wrreq) both_cnt <= both_cnt + 1;
    end

    // SPI core model: acks each launch after ack_lat cycles
    bit          ack_en = 1'b1;
    int          ack_lat = 10;
    bit          full_arm = 1'b0;
    int          full_at = 0;
    logic        go_prev = 1'b1;
    bit          cpend = 1'b0;
    int          ccnt = 0;
    logic [31:0] cword = '0;
    int          launches = 0;
    int          acks = 0;
    int          golow = 0;
    int          bad_go = 0;

    always @(posedge clk) begin
        if (fcnt != 0) fcnt <= fcnt - 1;
        if (!reset_n) begin
            go_prev         <= 1'b1;
            cpend           <= 1'b0;
            core_pack_ready <= 1'b0;
            golow           <= 0;
        end else begin
            go_prev         <= core_go_transfer;
            core_pack_ready <= 1'b0;
            if (go_prev && !core_go_transfer) begin
                launches <= launches + 1;
                if (ack_en) begin
                    cpend <= 1'b1;
                    ccnt  <= ack_lat;
                    cword <= core_data_write;
                end
            end else if (cpend) begin
                if (ccnt == 0) begin
                    core_pack_ready <= 1'b1;
                    core_data_read  <= cword ^ KEY;
                    cpend           <= 1'b0;
                    acks            <= acks + 1;
                    if (full_arm && acks == full_at) fcnt <= 100;
                end else begin
                    ccnt <= ccnt - 1;
                end
            end
            if (!core_go_transfer) begin
                golow <= golow + 1;
            end else if (golow != 0) begin
                if (golow != GO_LOW) bad_go <= bad_go + 1;
                golow <= 0;
            end
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_wq [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word();
        logic [31:0] w;
        w = $urandom | 32'h1;
        wmem[wr_tail % 1024] = w;
        wr_tail = wr_tail + 1;
        exp_wq.push_back(w);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push_word();
    endtask

    task automatic check_words(input int rb, input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = exp_wq.pop_front();
            chk("rd_data", rmem[(rb + i) % 1024], w ^ KEY);
        end
    endtask

    task automatic start_burst(input logic [7:0] cfg, input bit ab);
        @(negedge clk);
        cfg_words = cfg;
        start     = 1'b1;
        abort     = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL done_wait observed=%0b expected=1", done);
        end
    endtask

    task automatic wait_launch(input int target, input int lb);
        int k;
        k = 0;
        while (launches - lb < target && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("launch_reached", 32'(launches - lb), 32'(target));
    endtask

    task automatic wait_push(input int target, input int rb);
        int k;
        k = 0;
        while (rcnt - rb < target && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("push_reached", 32'(rcnt - rb), 32'(target));
    endtask

    task automatic do_burst(input logic [7:0] cfg, input int lat,
                            input bit ab, input int budget);
        int n, rb, lb, cyc;
        if (exp_wq.size() == 0) n = 0;
        else if (cfg == 0) n = exp_wq.size();
        else n = int'(cfg);
        rb = rcnt;
        lb = launches;
        ack_lat = lat;
        start_burst(cfg, ab);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err_timeout, 0);
        if (n > 0) begin
            chk("rdreq_fetch", wr_fifo_rdreq, 1);
            @(negedge clk);
            chk("go_low_latency", core_go_transfer, 0);
        end
        wait_done(budget, cyc);
        chk("words_done", words_done, 32'(n % 256));
        chk("launches", 32'(launches - lb), 32'(n));
        chk("pushes", 32'(rcnt - rb), 32'(n));
        check_words(rb, n);
        @(negedge clk);
        chk("busy_clear", busy, 0);
    endtask

    initial begin
        int cnt, cyc, rb, lb;
        logic [7:0] cfg;

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_words = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_words", words_done, 0);
        chk("rst_rdreq", wr_fifo_rdreq, 0);
        chk("rst_wrreq", rd_fifo_wrreq, 0);
        chk("rst_go", core_go_transfer, 1);
        chk("rst_wdata", core_data_write, 0);
        chk("rst_rdata", rd_fifo_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        push_n(3);
        do_burst(8'd3, 40, 1'b0, 1000);

        push_n(5);
        do_burst(8'd0, $urandom_range(1, 20), 1'b0, 1000);

        for (int it = 0; it < 6; it++) begin
            cnt = $urandom_range(1, 5);
            push_n(cnt);
            cfg = 8'($urandom_range(0, cnt));
            do_burst(cfg, $urandom_range(1, 30), 1'b0, 2000);
        end

        push_n(3);
        full_at  = acks + 1;
        full_arm = 1'b1;
        do_burst(8'd3, 20, 1'b0, 2000);
        full_arm = 1'b0;
        chk("full_no_push", 32'(push_full), 0);
        chk("full_no_timeout", err_timeout, 0);

        push_n(4);
        while (exp_wq.size() > 4) begin
            do_burst(8'd0, 5, 1'b0, 2000);
            push_n(4);
        end
        rb = rcnt;
        lb = launches;
        ack_lat = 40;
        start_burst(8'd4, 1'b0);
        wait_launch(2, lb);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(500, cyc);
        chk("abort_words", words_done, 2);
        repeat (20) @(negedge clk);
        chk("abort_launches", 32'(launches - lb), 2);
        chk("abort_pushes", 32'(rcnt - rb), 2);
        check_words(rb, 2);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        push_n(1);
        do_burst(8'd0, 7, 1'b1, 2000);

        do_burst(8'd3, 5, 1'b0, 50);

        ack_en = 1'b0;
        push_n(1);
        rb = rcnt;
        start_burst(8'd1, 1'b0);
        wait_done(TIMEOUT + 200, cyc);
        chk("timeout_cycles", 32'(cyc), 32'(TIMEOUT + 2 + GO_LOW));
        chk("timeout_err", err_timeout, 1);
        chk("timeout_words", words_done, 0);
        chk("timeout_no_push", 32'(rcnt - rb), 0);
        void'(exp_wq.pop_front());
        @(negedge clk);
        chk("timeout_sticky", err_timeout, 1);
        ack_en = 1'b1;

        push_n(2);
        rb = rcnt;
        lb = launches;
        ack_lat = 40;
        start_burst(8'd2, 1'b0);
        wait_launch(1, lb);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_go", core_go_transfer, 1);
        chk("mid_rst_wdata", core_data_write, 0);
        chk("mid_rst_rdata", rd_fifo_data, 0);
        chk("mid_rst_wrreq", rd_fifo_wrreq, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_rst_no_push", 32'(rcnt - rb), 0);
        void'(exp_wq.pop_front());
        push_n(2);
        do_burst(8'd0, 9, 1'b0, 1000);

        push_n(1);
        rb = rcnt;
        lb = launches;
        ack_lat = 5;
        start_burst(8'd3, 1'b0);
        wait_push(1, rb);
        repeat (20) @(negedge clk);
        chk("underrun_busy", busy, 1);
        chk("underrun_words", words_done, 1);
        chk("underrun_launches", 32'(launches - lb), 1);
        push_n(2);
        wait_done(1000, cyc);
        chk("underrun_final", words_done, 3);
        chk("underrun_pushes", 32'(rcnt - rb), 3);
        check_words(rb, 3);
        @(negedge clk);

        push_n(1);
        rb = rcnt;
        start_burst(8'd2, 1'b0);
        wait_push(1, rb);
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_underrun_fast", done, 1);
        wait_done(5, cyc);
        chk("abort_underrun_words", words_done, 1);
        check_words(rb, 1);
        @(negedge clk);

        push_n(258);
        do_burst(8'd0, 1, 1'b0, 8000);

        chk("go_width", 32'(bad_go), 0);
        chk("rd_wr_exclusive", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
